// File: rtl/prism_config_reader.sv
`default_nettype none
// ============================================================================
//  Module   : prism_config_reader
//  Purpose  : CPU-driven readback of a configuration latch array. A start
//             write walks the words from DEPTH-1 down to 0. Each word is
//             selected, given one cycle to settle, and captured into a hold
//             register. A rotate-XOR checksum is updated on every capture.
//             The CPU then pops the word, which advances the walk.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             debug_wr, debug_rd              one-cycle CPU strobes
//             address[5:0], data_in[31:0]     CPU register address / data
//             cfg_words[DEPTH*WIDTH-1:0]      flattened latch outputs
//             data_out[31:0]                  CPU read data (combinational)
//             busy, word_valid, done          status flags
//  Register map: 0x18 hold[31:0] | 0x1C hold[WIDTH-1:32] | 0x20 status
//                0x24 checksum   | all others read 0
//  Revision : 1.0 - initial release
// ============================================================================
module prism_config_reader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     debug_wr,
    input  logic                     debug_rd,
    input  logic [5:0]               address,
    input  logic [31:0]              data_in,
    input  logic [DEPTH*WIDTH-1:0]   cfg_words,
    output logic [31:0]              data_out,
    output logic                     busy,
    output logic                     word_valid,
    output logic                     done
);

    localparam int         HI_W      = WIDTH - 32;
    localparam logic [5:0] ADDR_LO   = 6'h18;
    localparam logic [5:0] ADDR_HI   = 6'h1C;
    localparam logic [5:0] ADDR_STAT = 6'h20;
    localparam logic [5:0] ADDR_CSUM = 6'h24;
    localparam logic [4:0] LAST_IDX  = 5'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        WAIT_RD = 3'd4,
        NEXT    = 3'd5
    } state_t;

    state_t             r_state;
    logic [4:0]         r_index;
    logic [4:0]         r_sel;
    logic [WIDTH-1:0]   r_hold;
    logic [31:0]        r_csum;
    logic               r_busy;
    logic               r_word_valid;
    logic               r_done;

    logic [WIDTH-1:0]   w_sel_word;
    logic [31:0]        w_sel_hi_pad;
    logic [31:0]        w_hold_hi_pad;
    logic               w_start;
    logic               w_abort;
    logic               w_pop;

    assign w_start = debug_wr && (address == ADDR_LO);
    assign w_abort = debug_wr && (address == ADDR_STAT) && data_in[0];
    assign w_pop   = debug_rd && (address == ADDR_HI);

    // Only bit 0 of the write data has a meaning (abort request).
    logic w_unused_data;
    assign w_unused_data = &{1'b0, data_in[31:1]};

    // Word-select mux driven by the registered select, so the latch array
    // sees a stable select for the whole SETTLE cycle before capture.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_sel == 5'(i)) begin
                w_sel_word = cfg_words[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_sel_hi_pad             = '0;
        w_sel_hi_pad[HI_W-1:0]   = w_sel_word[WIDTH-1:32];
        w_hold_hi_pad            = '0;
        w_hold_hi_pad[HI_W-1:0]  = r_hold[WIDTH-1:32];
    end

    // Busy and word_valid are registered alongside every state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_sel        <= '0;
            r_hold       <= '0;
            r_csum       <= '0;
            r_busy       <= 1'b0;
            r_word_valid <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_abort) begin
            // Abort wins over any pop in the same cycle; hold, checksum and
            // index are kept so the CPU can inspect where the walk stopped.
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_word_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_index <= LAST_IDX;
                        r_csum  <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    r_sel   <= r_index;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_hold       <= w_sel_word;
                    r_csum       <= {r_csum[30:0], r_csum[31]}
                                    ^ w_sel_word[31:0] ^ w_sel_hi_pad;
                    r_word_valid <= 1'b1;
                    r_state      <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (w_pop) begin
                        r_word_valid <= 1'b0;
                        r_state      <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_index == 5'd0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_index <= r_index - 5'd1;
                        r_state <= SELECT;
                    end
                end
                default: begin
                    r_busy       <= 1'b0;
                    r_word_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (address)
            ADDR_LO:   data_out = r_hold[31:0];
            ADDR_HI:   data_out = w_hold_hi_pad;
            ADDR_STAT: data_out = {19'd0, r_index, 5'd0, r_done, r_word_valid, r_busy};
            ADDR_CSUM: data_out = r_csum;
            default:   data_out = 32'd0;
        endcase
    end

    assign busy       = r_busy;
    assign word_valid = r_word_valid;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prism_config_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prism_config_reader
//  Purpose  : Directed self-checking bench for prism_config_reader.
//             Instance u_dut: DEPTH=8 WIDTH=64; instance u_dut40: DEPTH=2
//             WIDTH=40. Strobes are driven 1 ns after a rising edge and are
//             sampled on the following edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prism_config_reader;

    logic          clk = 1'b0;
    logic          rst_n;
    always #5 clk = ~clk;

    // 8 x 64 instance
    logic          wr, rd;
    logic [5:0]    addr;
    logic [31:0]   din;
    logic [511:0]  cfg;
    logic [31:0]   dout;
    logic          busy, wv, done;

    // 2 x 40 instance
    logic          wr2, rd2;
    logic [5:0]    addr2;
    logic [31:0]   din2;
    logic [79:0]   cfg2;
    logic [31:0]   dout2;
    logic          busy2, wv2, done2;

    int passed = 0;
    int total  = 0;

    prism_config_reader #(.DEPTH(8), .WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr), .debug_rd(rd),
        .address(addr), .data_in(din), .cfg_words(cfg),
        .data_out(dout), .busy(busy), .word_valid(wv), .done(done)
    );

    prism_config_reader #(.DEPTH(2), .WIDTH(40)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr2), .debug_rd(rd2),
        .address(addr2), .data_in(din2), .cfg_words(cfg2),
        .data_out(dout2), .busy(busy2), .word_valid(wv2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_wr(input logic [5:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; din = d;
        tick();
        wr = 1'b0; din = 32'd0;
    endtask

    task automatic strobe_rd(input logic [5:0] a);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
    endtask

    task automatic rd_reg(input logic [5:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic wait_wv(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (wv === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Expected checksum after the first n captures (words 7, 6, ...).
    function automatic logic [31:0] csum_model(input int n);
        logic [31:0] c = 32'd0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] lo = 32'h5000_0000 | 32'(7 - k);
            logic [31:0] hi = 32'hA000_0000 | 32'(7 - k);
            c = {c[30:0], c[31]} ^ lo ^ hi;
        end
        return c;
    endfunction

    function automatic logic [31:0] status(input int idx, input logic d,
                                           input logic v, input logic b);
        return (32'(idx) << 8) | {29'd0, d, v, b};
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({busy, wv, done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, wv, done}); else passed++;
        for (int a = 0; a < 4; a++) begin
            rd_reg(6'h18 + 6'(4 * a), d);
            total++; if (d !== 32'd0) $display("FAIL reset_reg%0d: got %h expected 00000000", a, d); else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if ({busy, wv, done} !== 3'b000) $display("FAIL reset_release: got %b expected 000", {busy, wv, done}); else passed++;
    endtask

    task automatic test_full_readback();
        logic [31:0] d;
        strobe_wr(6'h18, 32'd0);
        total++; if ({busy, wv} !== 2'b10) $display("FAIL start_busy: got %b expected 10", {busy, wv}); else passed++;
        tick(); tick();
        total++; if (wv !== 1'b0) $display("FAIL start_wv_early: got %b expected 0", wv); else passed++;
        tick();
        total++; if (wv !== 1'b1) $display("FAIL start_latency: got %b expected 1", wv); else passed++;
        for (int k = 0; k < 8; k++) begin
            int idx = 7 - k;
            rd_reg(6'h18, d);
            total++; if (d !== (32'h5000_0000 | 32'(idx))) $display("FAIL word%0d_lo: got %h expected %h", idx, d, 32'h5000_0000 | 32'(idx)); else passed++;
            rd_reg(6'h1C, d);
            total++; if (d !== (32'hA000_0000 | 32'(idx))) $display("FAIL word%0d_hi: got %h expected %h", idx, d, 32'hA000_0000 | 32'(idx)); else passed++;
            rd_reg(6'h20, d);
            total++; if (d !== status(idx, 1'b0, 1'b1, 1'b1)) $display("FAIL word%0d_status: got %h expected %h", idx, d, status(idx, 1'b0, 1'b1, 1'b1)); else passed++;
            strobe_rd(6'h1C);
            total++; if (wv !== 1'b0) $display("FAIL pop%0d_wv_low: got %b expected 0", idx, wv); else passed++;
            if (k < 7) begin
                tick(); tick(); tick();
                total++; if (wv !== 1'b0) $display("FAIL pop%0d_wv_early: got %b expected 0", idx, wv); else passed++;
                tick();
                total++; if (wv !== 1'b1) $display("FAIL pop%0d_latency: got %b expected 1", idx, wv); else passed++;
            end else begin
                total++; if ({busy, done} !== 2'b10) $display("FAIL last_pop_next: got %b expected 10", {busy, done}); else passed++;
                tick();
                total++; if ({busy, done} !== 2'b01) $display("FAIL last_pop_done: got %b expected 01", {busy, done}); else passed++;
            end
        end
        rd_reg(6'h24, d);
        total++; if (d !== csum_model(8)) $display("FAIL full_checksum: got %h expected %h", d, csum_model(8)); else passed++;
        rd_reg(6'h20, d);
        total++; if (d !== status(0, 1'b1, 1'b0, 1'b0)) $display("FAIL full_status: got %h expected %h", d, status(0, 1'b1, 1'b0, 1'b0)); else passed++;
        // Abort while idle only clears done.
        strobe_wr(6'h20, 32'd1);
        total++; if ({busy, wv, done} !== 3'b000) $display("FAIL idle_abort_flags: got %b expected 000", {busy, wv, done}); else passed++;
        rd_reg(6'h24, d);
        total++; if (d !== csum_model(8)) $display("FAIL idle_abort_csum: got %h expected %h", d, csum_model(8)); else passed++;
    endtask

    task automatic test_ignored_strobes();
        logic [31:0] d;
        bit ok;
        strobe_wr(6'h18, 32'd0);   // starts: SELECT
        strobe_wr(6'h18, 32'd0);   // sampled in SELECT, must be ignored
        strobe_rd(6'h1C);          // sampled in SETTLE, must be ignored
        tick();
        total++; if (wv !== 1'b1) $display("FAIL ignore_wv: got %b expected 1", wv); else passed++;
        rd_reg(6'h20, d);
        total++; if (d !== status(7, 1'b0, 1'b1, 1'b1)) $display("FAIL ignore_status: got %h expected %h", d, status(7, 1'b0, 1'b1, 1'b1)); else passed++;
        rd_reg(6'h24, d);
        total++; if (d !== csum_model(1)) $display("FAIL ignore_csum: got %h expected %h", d, csum_model(1)); else passed++;
        strobe_wr(6'h18, 32'd0);   // start while waiting for pop
        rd_reg(6'h24, d);
        total++; if (d !== csum_model(1)) $display("FAIL busy_start_csum: got %h expected %h", d, csum_model(1)); else passed++;
        rd_reg(6'h20, d);
        total++; if (d !== status(7, 1'b0, 1'b1, 1'b1)) $display("FAIL busy_start_status: got %h expected %h", d, status(7, 1'b0, 1'b1, 1'b1)); else passed++;
        strobe_rd(6'h18);          // read of low word never pops
        total++; if (wv !== 1'b1) $display("FAIL rd18_no_pop: got %b expected 1", wv); else passed++;
        strobe_rd(6'h1C);
        wait_wv(ok);
        total++; if (!ok) $display("FAIL second_word_timeout: got wv=%b expected 1", wv); else passed++;
        rd_reg(6'h18, d);
        total++; if (d !== 32'h5000_0006) $display("FAIL second_word_lo: got %h expected 50000006", d); else passed++;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        wr = 1'b1; rd = 1'b1; addr = 6'h20; din = 32'd1;
        tick();
        wr = 1'b0; rd = 1'b0; din = 32'd0;
        total++; if ({busy, wv, done} !== 3'b000) $display("FAIL abort_flags: got %b expected 000", {busy, wv, done}); else passed++;
        rd_reg(6'h20, d);
        total++; if (d !== status(6, 1'b0, 1'b0, 1'b0)) $display("FAIL abort_status: got %h expected %h", d, status(6, 1'b0, 1'b0, 1'b0)); else passed++;
        rd_reg(6'h24, d);
        total++; if (d !== csum_model(2)) $display("FAIL abort_csum: got %h expected %h", d, csum_model(2)); else passed++;
        rd_reg(6'h18, d);
        total++; if (d !== 32'h5000_0006) $display("FAIL abort_hold: got %h expected 50000006", d); else passed++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL abort_stays_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        strobe_wr(6'h18, 32'd0);   // SELECT
        tick();                    // SETTLE
        tick();                    // CAPTURE
        rst_n = 1'b0;
        #1;
        total++; if ({busy, wv, done} !== 3'b000) $display("FAIL midreset_flags: got %b expected 000", {busy, wv, done}); else passed++;
        rd_reg(6'h18, d);
        total++; if (d !== 32'd0) $display("FAIL midreset_hold: got %h expected 00000000", d); else passed++;
        rd_reg(6'h20, d);
        total++; if (d !== 32'd0) $display("FAIL midreset_status: got %h expected 00000000", d); else passed++;
        rd_reg(6'h24, d);
        total++; if (d !== 32'd0) $display("FAIL midreset_csum: got %h expected 00000000", d); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if ({busy, wv} !== 2'b00) $display("FAIL midreset_release: got %b expected 00", {busy, wv}); else passed++;
        strobe_wr(6'h18, 32'd0);
        wait_wv(ok);
        total++; if (!ok) $display("FAIL restart_timeout: got wv=%b expected 1", wv); else passed++;
        rd_reg(6'h18, d);
        total++; if (d !== 32'h5000_0007) $display("FAIL restart_first_word: got %h expected 50000007", d); else passed++;
    endtask

    task automatic test_width40();
        wr2 = 1'b1; addr2 = 6'h18;
        tick();
        wr2 = 1'b0;
        tick(); tick(); tick();
        total++; if (wv2 !== 1'b1) $display("FAIL w40_latency: got %b expected 1", wv2); else passed++;
        addr2 = 6'h1C; #1;
        total++; if (dout2 !== 32'h0000_00AB) $display("FAIL w40_hi: got %h expected 000000ab", dout2); else passed++;
        addr2 = 6'h18; #1;
        total++; if (dout2 !== 32'h1234_5678) $display("FAIL w40_lo: got %h expected 12345678", dout2); else passed++;
        addr2 = 6'h24; #1;
        total++; if (dout2 !== 32'h1234_56D3) $display("FAIL w40_csum: got %h expected 123456d3", dout2); else passed++;
        addr2 = 6'h30; #1;
        total++; if (dout2 !== 32'd0) $display("FAIL w40_unmapped: got %h expected 00000000", dout2); else passed++;
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; addr = 6'd0; din = 32'd0;
        wr2 = 1'b0; rd2 = 1'b0; addr2 = 6'd0; din2 = 32'd0;
        for (int i = 0; i < 8; i++) begin
            cfg[i*64 +: 64] = {32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)};
        end
        cfg2 = {40'hAB_1234_5678, 40'hCD_8765_4321};

        test_reset();
        test_full_readback();
        test_ignored_strobes();
        test_abort();
        test_reset_mid();
        test_width40();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
